// File: rtl/ex_mdu_iter.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// A single shared shift/add datapath produces {hi, lo} results for MULT*, DIV* and MADD*/MSUB*.
module ex_mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             cancel,
    output logic             stall_request,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;

    logic [2:0]       op_q;
    logic             neg_res, neg_rem;
    logic [CNT_W-1:0] counter;
    logic [W2-1:0]    acc, addend, base;
    logic [WIDTH-1:0] mplier;

    logic             in_signed, in_div, a_neg, b_neg, div_zero_req;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             op_div_q;

    logic [W2-1:0]    acc_next, mul_step, div_step, prod_fix, mul_res;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

    // Operand decode at the request boundary: magnitudes only for signed ops.
    always_comb begin
        in_signed    = ~op[0];
        in_div       = (op[2:1] == 2'b01);
        a_neg        = in_signed & operand_1[WIDTH-1];
        b_neg        = in_signed & operand_2[WIDTH-1];
        a_mag        = a_neg ? -operand_1 : operand_1;
        b_mag        = b_neg ? -operand_2 : operand_2;
        div_zero_req = in_div & (operand_2 == '0);
    end

    // One iteration step plus the sign fix / accumulate applied on entry to DONE.
    always_comb begin
        op_div_q  = (op_q[2:1] == 2'b01);
        mul_step  = acc + (mplier[0] ? addend : '0);
        rem_shift = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, addend[WIDTH-1:0]};
        rem_ge    = (rem_shift >= {1'b0, addend[WIDTH-1:0]});
        div_step  = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], rem_ge};
        acc_next  = op_div_q ? div_step : mul_step;

        prod_fix  = neg_res ? -acc_next : acc_next;
        mul_res   = prod_fix;
        if (op_q[2]) begin
            mul_res = op_q[1] ? (base - prod_fix) : (base + prod_fix);
        end
        quo_fix   = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc_next[W2-1:WIDTH] : acc_next[W2-1:WIDTH];
        res_hi    = op_div_q ? rem_fix : mul_res[W2-1:WIDTH];
        res_lo    = op_div_q ? quo_fix : mul_res[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start && !cancel) state_next = div_zero_req ? DONE : RUN;
            RUN: begin
                if (cancel)                 state_next = IDLE;
                else if (counter == LAST)   state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        stall_request = start & (state != DONE) & ~cancel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            op_q        <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            acc         <= '0;
            addend      <= '0;
            base        <= '0;
            mplier      <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            unique case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        op_q    <= op;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        base    <= {hi_in, lo_in};
                        counter <= '0;
                        mplier  <= b_mag;
                        // Divide keeps the dividend in acc and the divisor static in addend.
                        acc     <= in_div ? {{WIDTH{1'b0}}, a_mag} : '0;
                        addend  <= in_div ? {{WIDTH{1'b0}}, b_mag} : {{WIDTH{1'b0}}, a_mag};
                        if (div_zero_req) begin
                            hi_out      <= operand_1;
                            lo_out      <= '1;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        acc     <= acc_next;
                        mplier  <= mplier >> 1;
                        counter <= counter + CNT_W'(1);
                        if (!op_div_q) addend <= addend << 1;
                        if (state_next == DONE) begin
                            hi_out      <= res_hi;
                            lo_out      <= res_lo;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
